// File: rtl/parking_gate_controller.sv
// Parking gate front-end: debounces the entry/exit loop sensors, qualifies each
// vehicle with a card read, opens the barriers and serializes car_entered /
// car_exited event pulses so that at most one event is emitted per cycle.
//
// Ports:
//   clk, reset                  rising-edge clock, asynchronous active-high reset
//   entry_sensor, exit_sensor   raw loop sensors (1 = vehicle present)
//   *_card_valid, *_card_uni    one-cycle card read pulse and its class
//   uni_is_vacated_space        a uni space is free (checked at entry card read)
//   is_vacated_space            a non-uni space is free (checked at entry card read)
//   car_entered/car_exited      one-cycle event pulses, with is_uni_* class flags
//   entry_gate_open/exit_gate_open  barrier commands
//   entry_denied                one-cycle pulse: entry card read, no space of that class
module parking_gate_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned GATE_TIMEOUT    = 1000,
    parameter int unsigned TMR_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic entry_sensor,
    input  logic entry_card_valid,
    input  logic entry_card_uni,
    input  logic exit_sensor,
    input  logic exit_card_valid,
    input  logic exit_card_uni,
    input  logic uni_is_vacated_space,
    input  logic is_vacated_space,
    output logic car_entered,
    output logic is_uni_car_entered,
    output logic car_exited,
    output logic is_uni_car_exited,
    output logic entry_gate_open,
    output logic exit_gate_open,
    output logic entry_denied
);

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StWaitCard, StOpen, StPass} gate_st_e;

    // Index 0 = entry gate, index 1 = exit gate.
    logic [1:0]       sens_raw, card_v, card_u, accept;
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       deb_q, deb_d, deb_rise, deb_fall;
    logic [DbW-1:0]   db_cnt_q [2];
    logic [DbW-1:0]   db_cnt_d [2];
    gate_st_e         st_q [2];
    gate_st_e         st_d [2];
    logic [TMR_W-1:0] tmr_q [2];
    logic [TMR_W-1:0] tmr_d [2];
    logic [1:0]       cls_q, cls_d;
    logic [1:0]       gate_q, gate_d;
    logic [1:0]       pass_req;
    logic             denied_q, denied_d;
    logic             pend_q, pend_d, pend_uni_q, pend_uni_d;
    logic             ent_q, ent_d, ent_uni_q, ent_uni_d;
    logic             ext_q, ext_d, ext_uni_q, ext_uni_d;
    logic             ent_src, ent_src_uni;

    assign sens_raw = {exit_sensor, entry_sensor};
    assign card_v   = {exit_card_valid, entry_card_valid};
    assign card_u   = {exit_card_uni, entry_card_uni};
    // Exit cards are always accepted; entry needs a free space of the card's class.
    assign accept   = {1'b1, entry_card_uni ? uni_is_vacated_space : is_vacated_space};

    // Debounce: the level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i]    = deb_q[i];
            db_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign deb_rise = deb_d & ~deb_q;
    assign deb_fall = ~deb_d & deb_q;

    // Gate FSMs
    always_comb begin
        denied_d = 1'b0;
        pass_req = '0;
        cls_d    = cls_q;
        for (int i = 0; i < 2; i++) begin
            st_d[i]  = st_q[i];
            tmr_d[i] = tmr_q[i];
            case (st_q[i])
                StIdle: begin
                    if (deb_rise[i]) begin
                        st_d[i]  = StWaitCard;
                        tmr_d[i] = '0;
                    end
                end
                StWaitCard: begin
                    if (deb_fall[i] || tmr_q[i] == TMR_W'(GATE_TIMEOUT - 1)) begin
                        st_d[i] = StIdle;
                    end else begin
                        tmr_d[i] = tmr_q[i] + 1'b1;
                        if (card_v[i]) begin
                            if (accept[i]) begin
                                cls_d[i] = card_u[i];
                                st_d[i]  = StOpen;
                                tmr_d[i] = '0;
                            end else begin
                                // Only the entry gate can refuse; timer keeps running.
                                denied_d = 1'b1;
                            end
                        end
                    end
                end
                StOpen: begin
                    if (deb_fall[i]) begin
                        st_d[i] = StPass;
                    end else if (tmr_q[i] == TMR_W'(GATE_TIMEOUT - 1)) begin
                        st_d[i] = StIdle;
                    end else begin
                        tmr_d[i] = tmr_q[i] + 1'b1;
                    end
                end
                StPass: begin
                    pass_req[i] = 1'b1;
                    st_d[i]     = StIdle;
                end
                default: st_d[i] = StIdle;
            endcase
            gate_d[i] = (st_d[i] == StOpen);
        end
    end

    // Event arbiter: exit wins; a colliding entry event waits in the pending slot.
    always_comb begin
        ext_d       = pass_req[1];
        ext_uni_d   = pass_req[1] & cls_q[1];
        ent_src     = pend_q | pass_req[0];
        ent_src_uni = pend_q ? pend_uni_q : cls_q[0];
        ent_d       = 1'b0;
        ent_uni_d   = 1'b0;
        pend_d      = 1'b0;
        pend_uni_d  = 1'b0;
        if (ent_src) begin
            if (pass_req[1]) begin
                pend_d     = 1'b1;
                pend_uni_d = ent_src_uni;
            end else begin
                ent_d     = 1'b1;
                ent_uni_d = ent_src_uni;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            cls_q      <= '0;
            gate_q     <= '0;
            denied_q   <= 1'b0;
            pend_q     <= 1'b0;
            pend_uni_q <= 1'b0;
            ent_q      <= 1'b0;
            ent_uni_q  <= 1'b0;
            ext_q      <= 1'b0;
            ext_uni_q  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
                st_q[i]     <= StIdle;
                tmr_q[i]    <= '0;
            end
        end else begin
            sync1_q    <= sens_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            cls_q      <= cls_d;
            gate_q     <= gate_d;
            denied_q   <= denied_d;
            pend_q     <= pend_d;
            pend_uni_q <= pend_uni_d;
            ent_q      <= ent_d;
            ent_uni_q  <= ent_uni_d;
            ext_q      <= ext_d;
            ext_uni_q  <= ext_uni_d;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
                st_q[i]     <= st_d[i];
                tmr_q[i]    <= tmr_d[i];
            end
        end
    end

    assign car_entered        = ent_q;
    assign is_uni_car_entered = ent_uni_q;
    assign car_exited         = ext_q;
    assign is_uni_car_exited  = ext_uni_q;
    assign entry_gate_open    = gate_q[0];
    assign exit_gate_open     = gate_q[1];
    assign entry_denied       = denied_q;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed bench for parking_gate_controller with an event scoreboard.
module tb_parking_gate_controller;

    localparam int unsigned GT = 64;

    logic clk = 1'b0;
    logic reset;
    logic entry_sensor, entry_card_valid, entry_card_uni;
    logic exit_sensor, exit_card_valid, exit_card_uni;
    logic uni_is_vacated_space, is_vacated_space;
    logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
    logic entry_gate_open, exit_gate_open, entry_denied;

    typedef struct packed {
        logic is_exit;
        logic uni;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  ev_seen = 0;
    int  cyc = 0;
    int  last_exit_cyc = -1;
    int  last_entry_cyc = -1;

    parking_gate_controller #(
        .DEBOUNCE_CYCLES(4),
        .GATE_TIMEOUT   (GT),
        .TMR_W          (16)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .entry_sensor        (entry_sensor),
        .entry_card_valid    (entry_card_valid),
        .entry_card_uni      (entry_card_uni),
        .exit_sensor         (exit_sensor),
        .exit_card_valid     (exit_card_valid),
        .exit_card_uni       (exit_card_uni),
        .uni_is_vacated_space(uni_is_vacated_space),
        .is_vacated_space    (is_vacated_space),
        .car_entered         (car_entered),
        .is_uni_car_entered  (is_uni_car_entered),
        .car_exited          (car_exited),
        .is_uni_car_exited   (is_uni_car_exited),
        .entry_gate_open     (entry_gate_open),
        .exit_gate_open      (exit_gate_open),
        .entry_denied        (entry_denied)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
                entry_gate_open, exit_gate_open, entry_denied};
    endfunction

    task automatic push_ev(input logic is_exit, input logic uni);
        ev_t e;
        e.is_exit = is_exit;
        e.uni     = uni;
        exp_q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle card pulses; returns 1 time unit after the edge that samples them.
    task automatic card(input logic en_v, input logic en_u, input logic ex_v, input logic ex_u);
        entry_card_valid = en_v;
        entry_card_uni   = en_u;
        exit_card_valid  = ex_v;
        exit_card_uni    = ex_u;
        @(posedge clk);
        #1;
        entry_card_valid = 1'b0;
        exit_card_valid  = 1'b0;
    endtask

    task automatic wait_ev(input int target, input string tag);
        for (int k = 0; k < 40 && ev_seen < target; k++) @(posedge clk);
        #1;
        check(tag, ev_seen >= target, 1);
    endtask

    // Scoreboard monitor: every emitted event must match the queue head.
    always @(negedge clk) begin
        ev_t got;
        ev_t want;
        if (!reset && (car_entered | car_exited | is_uni_car_entered | is_uni_car_exited)) begin
            check("evt_exclusive", {31'd0, car_entered & car_exited}, 0);
            check("uni_entry_gated", {31'd0, is_uni_car_entered & ~car_entered}, 0);
            check("uni_exit_gated", {31'd0, is_uni_car_exited & ~car_exited}, 0);
            got.is_exit = car_exited;
            got.uni     = car_exited ? is_uni_car_exited : is_uni_car_entered;
            if (car_exited) last_exit_cyc = cyc;
            if (car_entered) last_entry_cyc = cyc;
            ev_seen++;
            check("evt_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                check("evt_kind", got.is_exit, want.is_exit);
                check("evt_uni", got.uni, want.uni);
            end
        end
    end

    initial begin
        int tgt;
        int base;
        reset                = 1'b1;
        entry_sensor         = 1'b0;
        entry_card_valid     = 1'b0;
        entry_card_uni       = 1'b0;
        exit_sensor          = 1'b0;
        exit_card_valid      = 1'b0;
        exit_card_uni        = 1'b0;
        uni_is_vacated_space = 1'b0;
        is_vacated_space     = 1'b0;
        cycles(3);
        check("reset_outputs", outs(), 0);
        reset = 1'b0;
        cycles(2);
        check("idle_outputs", outs(), 0);

        // Uni entry, normal pass; losing space while open must not close the gate.
        uni_is_vacated_space = 1'b1;
        entry_sensor = 1'b1;
        cycles(10);
        check("uni_gate_before_card", entry_gate_open, 0);
        card(1'b1, 1'b1, 1'b0, 1'b0);
        check("uni_gate_after_card", entry_gate_open, 1);
        uni_is_vacated_space = 1'b0;
        cycles(3);
        check("uni_gate_space_lost", entry_gate_open, 1);
        push_ev(1'b0, 1'b1);
        tgt = ev_seen + 1;
        entry_sensor = 1'b0;
        cycles(2);
        check("uni_gate_during_debounce", entry_gate_open, 1);
        wait_ev(tgt, "uni_entry_event");
        check("uni_gate_closed", entry_gate_open, 0);

        // Glitch shorter than the debounce window: a later card must be ignored.
        uni_is_vacated_space = 1'b1;
        base = ev_seen;
        entry_sensor = 1'b1;
        cycles(2);
        entry_sensor = 1'b0;
        cycles(8);
        card(1'b1, 1'b1, 1'b0, 1'b0);
        check("glitch_gate", entry_gate_open, 0);
        cycles(20);
        check("glitch_no_event", ev_seen, base);

        // Class mismatches deny; matching class opens.
        is_vacated_space     = 1'b0;
        uni_is_vacated_space = 1'b1;
        entry_sensor = 1'b1;
        cycles(10);
        card(1'b1, 1'b0, 1'b0, 1'b0);
        check("deny_nonuni_pulse", entry_denied, 1);
        check("deny_nonuni_gate", entry_gate_open, 0);
        cycles(1);
        check("deny_one_cycle", entry_denied, 0);
        uni_is_vacated_space = 1'b0;
        is_vacated_space     = 1'b1;
        card(1'b1, 1'b1, 1'b0, 1'b0);
        check("deny_uni_pulse", entry_denied, 1);
        check("deny_uni_gate", entry_gate_open, 0);
        card(1'b1, 1'b0, 1'b0, 1'b0);
        check("nonuni_accept_gate", entry_gate_open, 1);
        check("nonuni_accept_nodeny", entry_denied, 0);
        push_ev(1'b0, 1'b0);
        tgt = ev_seen + 1;
        entry_sensor = 1'b0;
        wait_ev(tgt, "nonuni_entry_event");

        // Simultaneous pass: exit first, entry exactly one cycle later.
        entry_sensor = 1'b1;
        exit_sensor  = 1'b1;
        cycles(10);
        card(1'b1, 1'b0, 1'b1, 1'b1);
        check("both_entry_gate", entry_gate_open, 1);
        check("both_exit_gate", exit_gate_open, 1);
        push_ev(1'b1, 1'b1);
        push_ev(1'b0, 1'b0);
        tgt = ev_seen + 2;
        entry_sensor = 1'b0;
        exit_sensor  = 1'b0;
        wait_ev(tgt, "both_events");
        check("both_entry_after_exit", last_entry_cyc - last_exit_cyc, 1);
        check("both_gates_closed", {entry_gate_open, exit_gate_open}, 0);

        // No card before the timeout: the late card must be ignored.
        uni_is_vacated_space = 1'b1;
        base = ev_seen;
        entry_sensor = 1'b1;
        cycles(GT + 20);
        card(1'b1, 1'b1, 1'b0, 1'b0);
        check("waitcard_timeout_gate", entry_gate_open, 0);
        entry_sensor = 1'b0;
        cycles(15);
        check("waitcard_timeout_no_event", ev_seen, base);

        // Open gate, car never leaves: closes exactly after GT open cycles.
        entry_sensor = 1'b1;
        cycles(10);
        card(1'b1, 1'b1, 1'b0, 1'b0);
        check("open_timeout_start", entry_gate_open, 1);
        cycles(GT - 1);
        check("open_timeout_last", entry_gate_open, 1);
        cycles(1);
        check("open_timeout_closed", entry_gate_open, 0);
        entry_sensor = 1'b0;
        cycles(15);
        check("open_timeout_no_event", ev_seen, base);

        // Asynchronous reset while open.
        entry_sensor = 1'b1;
        cycles(10);
        card(1'b1, 1'b1, 1'b0, 1'b0);
        check("pre_reset_gate", entry_gate_open, 1);
        cycles(2);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outputs", outs(), 0);
        entry_sensor = 1'b0;
        cycles(3);
        reset = 1'b0;
        cycles(20);
        check("post_reset_no_event", ev_seen, base);

        // Normal sequence after reset.
        entry_sensor = 1'b1;
        cycles(10);
        card(1'b1, 1'b1, 1'b0, 1'b0);
        check("post_reset_gate", entry_gate_open, 1);
        push_ev(1'b0, 1'b1);
        tgt = ev_seen + 1;
        entry_sensor = 1'b0;
        wait_ev(tgt, "post_reset_event");
        cycles(10);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
